// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM burst controller.
//   state_t      : 2-bit FSM state encoding (IDLE / SETUP / ACCESS / RECOVER)
//   DEF_*        : default bus widths and phase timings
//   phase_load() : phase-counter preload for an N-cycle phase (N-1, clamped at 0)
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_ACCESS  = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    localparam int DEF_ADDR_WIDTH       = 15;
    localparam int DEF_DATA_WIDTH       = 32;
    localparam int DEF_LEN_WIDTH        = 3;
    localparam int DEF_CNT_WIDTH        = 5;
    localparam int DEF_SETUP_CYCLES     = 1;
    localparam int DEF_RD_ACCESS_CYCLES = 10;
    localparam int DEF_WR_ACCESS_CYCLES = 10;
    localparam int DEF_RECOVER_CYCLES   = 1;

    function automatic int phase_load(input int cycles);
        return (cycles > 0) ? cycles - 1 : 0;
    endfunction

endpackage

// File: rtl/sram_burst_controller_if.sv
// Requester-side bus of the SRAM burst controller.
//   req_valid/req_ready : request handshake
//   req_we, req_addr, req_len : burst descriptor (sampled on accept only)
//   wdata/wdata_ack     : write beat and its consume strobe
//   rdata/rdata_valid   : read beat and its one-cycle qualifier
//   done                : one-cycle burst-complete pulse
// master = requester (arbiter side), slave = controller.
interface sram_burst_controller_if
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [LEN_WIDTH-1:0]  req_len;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wdata_ack;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rdata_valid;
    logic                  done;

    modport master (
        output req_valid, req_we, req_addr, req_len, wdata,
        input  req_ready, wdata_ack, rdata, rdata_valid, done
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_len, wdata,
        output req_ready, wdata_ack, rdata, rdata_valid, done
    );

endinterface

// File: rtl/sram_phase_counter.sv
// Down-counter timing one SETUP / ACCESS / RECOVER phase.
//   clk, reset_n : clock, asynchronous active-low reset
//   load, load_val : preload with (phase length - 1) on phase entry
//   en           : count down while a phase is active (stops at zero)
//   zero         : counter is zero, i.e. this is the last cycle of the phase
module sram_phase_counter
    import sram_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_val,
    input  logic                 en,
    output logic                 zero
);

    logic [CNT_WIDTH-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - CNT_WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sram_burst_controller.sv
// Burst sequencer for an asynchronous SRAM.
//   clk, reset_n  : clock, asynchronous active-low reset
//   host          : requester bus (slave modport of sram_burst_controller_if)
//   sram_addr     : registered word address, increments per beat (wraps)
//   sram_dout     : registered write data, sram_dout_en = tristate enable
//   sram_din      : read data from the array, captured on last ACCESS cycle
//   ce_n/oe_n/we_n: registered active-low chip / output / write enables
// Each beat runs SETUP -> ACCESS -> RECOVER; SETUP and RECOVER are
// dropped entirely when their cycle count is 0.
module sram_burst_controller
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH        = DEF_LEN_WIDTH,
    parameter int CNT_WIDTH        = DEF_CNT_WIDTH,
    parameter int SETUP_CYCLES     = DEF_SETUP_CYCLES,
    parameter int RD_ACCESS_CYCLES = DEF_RD_ACCESS_CYCLES,
    parameter int WR_ACCESS_CYCLES = DEF_WR_ACCESS_CYCLES,
    parameter int RECOVER_CYCLES   = DEF_RECOVER_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset_n,
    sram_burst_controller_if.slave host,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_dout,
    output logic                  sram_dout_en,
    input  logic [DATA_WIDTH-1:0] sram_din,
    output logic                  ce_n,
    output logic                  oe_n,
    output logic                  we_n
);

    localparam logic [CNT_WIDTH-1:0] SETUP_LD = CNT_WIDTH'(phase_load(SETUP_CYCLES));
    localparam logic [CNT_WIDTH-1:0] RD_LD    = CNT_WIDTH'(phase_load(RD_ACCESS_CYCLES));
    localparam logic [CNT_WIDTH-1:0] WR_LD    = CNT_WIDTH'(phase_load(WR_ACCESS_CYCLES));
    localparam logic [CNT_WIDTH-1:0] REC_LD   = CNT_WIDTH'(phase_load(RECOVER_CYCLES));
    localparam bit HAS_SETUP   = (SETUP_CYCLES != 0);
    localparam bit HAS_RECOVER = (RECOVER_CYCLES != 0);

    state_t               state;
    logic                 burst_we;
    logic [LEN_WIDTH-1:0] beats_left;
    logic                 cnt_zero;
    logic                 cnt_load;
    logic [CNT_WIDTH-1:0] cnt_load_val;
    logic                 accept;
    logic                 setup_end;
    logic                 access_end;
    logic                 beat_end;
    logic                 more_beats;
    logic                 beat_we;

    // Phase-boundary decode shared by the FSM and the phase counter.
    always_comb begin
        accept     = host.req_valid && host.req_ready;
        setup_end  = (state == ST_SETUP) && cnt_zero;
        access_end = (state == ST_ACCESS) && cnt_zero;
        beat_end   = HAS_RECOVER ? ((state == ST_RECOVER) && cnt_zero) : access_end;
        more_beats = beat_end && (beats_left != '0);
        // Direction of the beat about to start: the new request on accept,
        // otherwise the latched direction of the running burst.
        beat_we    = accept ? host.req_we : burst_we;

        host.wdata_ack = (accept && host.req_we) || (more_beats && burst_we);

        cnt_load     = 1'b0;
        cnt_load_val = '0;
        if (accept || more_beats) begin
            cnt_load     = 1'b1;
            cnt_load_val = HAS_SETUP ? SETUP_LD : (beat_we ? WR_LD : RD_LD);
        end else if (setup_end) begin
            cnt_load     = 1'b1;
            cnt_load_val = burst_we ? WR_LD : RD_LD;
        end else if (access_end && HAS_RECOVER) begin
            cnt_load     = 1'b1;
            cnt_load_val = REC_LD;
        end
    end

    sram_phase_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_phase_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (state != ST_IDLE),
        .zero     (cnt_zero)
    );

    // Outputs are registered from the transition being taken, so the
    // strobes always match the state that is being entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= ST_IDLE;
            burst_we         <= 1'b0;
            beats_left       <= '0;
            sram_addr        <= '0;
            sram_dout        <= '0;
            sram_dout_en     <= 1'b0;
            ce_n             <= 1'b1;
            oe_n             <= 1'b1;
            we_n             <= 1'b1;
            host.req_ready   <= 1'b0;
            host.rdata       <= '0;
            host.rdata_valid <= 1'b0;
            host.done        <= 1'b0;
        end else begin
            host.rdata_valid <= 1'b0;
            host.done        <= 1'b0;

            if (access_end && !burst_we) begin
                host.rdata       <= sram_din;
                host.rdata_valid <= 1'b1;
            end

            if (accept || more_beats) begin
                state          <= HAS_SETUP ? ST_SETUP : ST_ACCESS;
                ce_n           <= 1'b0;
                oe_n           <= HAS_SETUP || beat_we;
                we_n           <= HAS_SETUP || !beat_we;
                sram_dout_en   <= beat_we;
                host.req_ready <= 1'b0;
                if (accept) begin
                    burst_we   <= host.req_we;
                    sram_addr  <= host.req_addr;
                    beats_left <= host.req_len;
                end else begin
                    beats_left <= beats_left - LEN_WIDTH'(1);
                    sram_addr  <= sram_addr + ADDR_WIDTH'(1);
                end
                if (beat_we) begin
                    sram_dout <= host.wdata;
                end
            end else if (beat_end) begin
                state          <= ST_IDLE;
                ce_n           <= 1'b1;
                oe_n           <= 1'b1;
                we_n           <= 1'b1;
                sram_dout_en   <= 1'b0;
                host.done      <= 1'b1;
                host.req_ready <= 1'b1;
            end else if (setup_end) begin
                state        <= ST_ACCESS;
                oe_n         <= burst_we;
                we_n         <= !burst_we;
                sram_dout_en <= burst_we;
            end else if (access_end) begin
                // Only reached with a RECOVER phase; write data stays driven
                // through it for hold time.
                state <= ST_RECOVER;
                oe_n  <= 1'b1;
                we_n  <= 1'b1;
            end else if (state == ST_IDLE) begin
                host.req_ready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_burst_controller.sv
// Testbench for sram_burst_controller: two instances (default timing and a
// minimal SETUP=0 / RECOVER=0 / 1-cycle-read timing) driven from a per-cycle
// expected trace computed from the burst timing rules.
module tb_sram_burst_controller;
    localparam int AW = 15;
    localparam int DW = 32;
    localparam int LW = 3;
    localparam int MAXC = 4096;
    localparam int S0 = 1, RA0 = 10, WA0 = 10, R0 = 1;
    localparam int S1 = 0, RA1 = 1,  WA1 = 3,  R1 = 0;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic          sel = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [LW-1:0] req_len = '0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] din_seed = '0;

    sram_burst_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus0 ();
    sram_burst_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus1 ();

    assign bus0.req_valid = req_valid && (sel == 1'b0);
    assign bus1.req_valid = req_valid && (sel == 1'b1);
    assign bus0.req_we = req_we;     assign bus1.req_we = req_we;
    assign bus0.req_addr = req_addr; assign bus1.req_addr = req_addr;
    assign bus0.req_len = req_len;   assign bus1.req_len = req_len;
    assign bus0.wdata = wdata;       assign bus1.wdata = wdata;

    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] dout0, dout1, din0, din1;
    logic          en0, en1, ce0, ce1, oe0, oe1, we0, we1;

    // SRAM array model: each word holds a fixed hash of its address.
    assign din0 = (32'(addr0) * 32'h9E3779B1) ^ din_seed;
    assign din1 = (32'(addr1) * 32'h9E3779B1) ^ din_seed;

    sram_burst_controller u_dut0 (
        .clk(clk), .reset_n(reset_n), .host(bus0.slave),
        .sram_addr(addr0), .sram_dout(dout0), .sram_dout_en(en0), .sram_din(din0),
        .ce_n(ce0), .oe_n(oe0), .we_n(we0)
    );

    sram_burst_controller #(
        .SETUP_CYCLES(S1), .RD_ACCESS_CYCLES(RA1), .WR_ACCESS_CYCLES(WA1), .RECOVER_CYCLES(R1)
    ) u_dut1 (
        .clk(clk), .reset_n(reset_n), .host(bus1.slave),
        .sram_addr(addr1), .sram_dout(dout1), .sram_dout_en(en1), .sram_din(din1),
        .ce_n(ce1), .oe_n(oe1), .we_n(we1)
    );

    // Observed outputs of the selected instance: {ce,oe,we,en,rv,done,ack,ready}
    logic [7:0]    o_ctl;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_dout, o_rdata;
    always_comb begin
        if (sel == 1'b0) begin
            o_ctl   = {ce0, oe0, we0, en0, bus0.rdata_valid, bus0.done, bus0.wdata_ack, bus0.req_ready};
            o_addr  = addr0;
            o_dout  = dout0;
            o_rdata = bus0.rdata;
        end else begin
            o_ctl   = {ce1, oe1, we1, en1, bus1.rdata_valid, bus1.done, bus1.wdata_ack, bus1.req_ready};
            o_addr  = addr1;
            o_dout  = dout1;
            o_rdata = bus1.rdata;
        end
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [DW-1:0] din_fn(input logic [AW-1:0] a);
        return (32'(a) * 32'h9E3779B1) ^ din_seed;
    endfunction

    // Burst list for one run
    int            nb;
    logic          bw[16];
    logic [AW-1:0] ba[16];
    logic [LW-1:0] bl[16];
    int            bg[16];   // idle cycles before accept; 0 after a burst = held back-to-back

    // Expected trace and stimulus schedule
    logic [3:0]    e_str[MAXC];
    logic          e_rv[MAXC], e_done[MAXC], e_ack[MAXC], e_ready[MAXC], e_busy[MAXC];
    logic [AW-1:0] e_addr[MAXC];
    logic [DW-1:0] e_dout[MAXC], e_rdata[MAXC];
    logic          s_valid[MAXC], s_we[MAXC];
    logic [AW-1:0] s_addr[MAXC];
    logic [LW-1:0] s_len[MAXC];
    logic [DW-1:0] wq[$];

    task automatic build(input logic fixed_wd, output int last);
        int S, R, A, P, t_acc, prev_T, prev_acc, T, c0, vstart;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        S = sel ? S1 : S0;
        R = sel ? R1 : R0;
        for (int c = 0; c < MAXC; c++) begin
            e_str[c] = 4'b1110; e_rv[c] = 1'b0; e_done[c] = 1'b0; e_ack[c] = 1'b0;
            e_ready[c] = 1'b1; e_busy[c] = 1'b0;
            s_valid[c] = 1'b0; s_we[c] = 1'($urandom); s_addr[c] = AW'($urandom); s_len[c] = LW'($urandom);
        end
        wq.delete();
        prev_T = 0;
        prev_acc = 0;
        for (int k = 0; k < nb; k++) begin
            A = bw[k] ? (sel ? WA1 : WA0) : (sel ? RA1 : RA0);
            P = S + A + R;
            t_acc = (k == 0) ? bg[k] : prev_T + bg[k];
            vstart = (k > 0 && bg[k] == 0) ? prev_acc + 1 : t_acc;
            for (int c = vstart; c <= t_acc; c++) begin
                s_valid[c] = 1'b1; s_we[c] = bw[k]; s_addr[c] = ba[k]; s_len[c] = bl[k];
            end
            e_ack[t_acc] = bw[k];
            for (int b = 0; b <= int'(bl[k]); b++) begin
                c0 = t_acc + 1 + b * P;
                a = ba[k] + AW'(b);
                wd = fixed_wd ? DW'(32'hA0 + b) : DW'($urandom);
                if (bw[k]) wq.push_back(wd);
                for (int i = 0; i < P; i++) begin
                    e_busy[c0+i] = 1'b1; e_ready[c0+i] = 1'b0;
                    e_addr[c0+i] = a; e_dout[c0+i] = wd;
                    if (i >= S && i < S + A) e_str[c0+i] = bw[k] ? 4'b0101 : 4'b0010;
                    else e_str[c0+i] = {3'b011, bw[k]};
                end
                if (!bw[k]) begin
                    e_rv[c0+S+A] = 1'b1;
                    e_rdata[c0+S+A] = din_fn(a);
                end
                if (bw[k] && b < int'(bl[k])) e_ack[c0+P-1] = 1'b1;
            end
            T = t_acc + 1 + (int'(bl[k]) + 1) * P;
            e_done[T] = 1'b1;
            prev_T = T;
            prev_acc = t_acc;
        end
        last = prev_T + 2;
    endtask

    task automatic run_seq(input logic s, input logic fixed_wd);
        int last;
        int widx;
        sel = s;
        build(fixed_wd, last);
        widx = 0;
        for (int c = 0; c <= last; c++) begin
            @(posedge clk); #1;
            req_valid = s_valid[c];
            req_we = s_we[c];
            req_addr = s_addr[c];
            req_len = s_len[c];
            wdata = (widx < wq.size()) ? wq[widx] : DW'($urandom);
            @(negedge clk);
            chk($sformatf("ctl%0d@%0d", s, c), 64'(o_ctl),
                64'({e_str[c], e_rv[c], e_done[c], e_ack[c], e_ready[c]}));
            if (e_busy[c]) chk($sformatf("addr%0d@%0d", s, c), 64'(o_addr), 64'(e_addr[c]));
            if (e_str[c][0]) chk($sformatf("dout%0d@%0d", s, c), 64'(o_dout), 64'(e_dout[c]));
            if (e_rv[c]) chk($sformatf("rdata%0d@%0d", s, c), 64'(o_rdata), 64'(e_rdata[c]));
            if (e_ack[c]) widx++;
        end
        req_valid = 1'b0;
    endtask

    task automatic gen_random(input int n);
        nb = n;
        for (int k = 0; k < n; k++) begin
            bw[k] = 1'($urandom);
            ba[k] = AW'($urandom);
            bl[k] = LW'($urandom);
            bg[k] = (k == 0) ? $urandom_range(0, 2) : $urandom_range(0, 3);
        end
    endtask

    initial begin
        // Reset state of both instances
        #7;
        sel = 1'b0; #1;
        chk("rst_ctl0", 64'(o_ctl), 64'h0000_00E0);
        chk("rst_data0", {o_addr, o_dout, o_rdata[16:0]}, 64'h0);
        sel = 1'b1; #1;
        chk("rst_ctl1", 64'(o_ctl), 64'h0000_00E0);
        sel = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // Single read at 0x0010 returning 0xDEADBEEF
        din_seed = 32'hDEADBEEF ^ (32'h0000_0010 * 32'h9E3779B1);
        nb = 1; bw[0] = 1'b0; ba[0] = AW'(16'h0010); bl[0] = '0; bg[0] = 0;
        run_seq(1'b0, 1'b0);
        chk("rd_deadbeef", 64'(o_rdata), 64'hDEAD_BEEF);

        // 4-beat write wrapping at the top of the address space, read held
        // valid throughout and accepted in the write's done cycle
        din_seed = DW'($urandom);
        nb = 2;
        bw[0] = 1'b1; ba[0] = AW'(16'h7FFE); bl[0] = LW'(3); bg[0] = 0;
        bw[1] = 1'b0; ba[1] = AW'(16'h1234); bl[1] = LW'(1); bg[1] = 0;
        run_seq(1'b0, 1'b1);

        // Minimal timing: 2-beat read, done 3 cycles after accept
        nb = 1; bw[0] = 1'b0; ba[0] = AW'(16'h7FFF); bl[0] = LW'(1); bg[0] = 0;
        run_seq(1'b1, 1'b0);

        // Randomized burst mixes on both timings
        for (int r = 0; r < 2; r++) begin
            din_seed = DW'($urandom);
            gen_random(4);
            run_seq(1'b0, 1'b0);
        end
        for (int r = 0; r < 3; r++) begin
            din_seed = DW'($urandom);
            gen_random(6);
            run_seq(1'b1, 1'b0);
        end

        // Reset in the middle of a 4-beat write
        sel = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = AW'($urandom); req_len = LW'(3);
        wdata = DW'($urandom);
        @(negedge clk);
        chk("rst_wr_ack", 64'(o_ctl[1]), 64'h1);
        for (int c = 1; c < 5; c++) begin
            @(posedge clk); #1 req_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("rst_wr_done@%0d", c), 64'(o_ctl[2]), 64'h0);
        end
        chk("pre_rst_we", 64'(o_ctl[5]), 64'h0);
        @(posedge clk); #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_str", 64'(o_ctl[7:4]), 64'hE);
        chk("mid_rst_flags", 64'(o_ctl[3:0]), 64'h0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_done0", 64'(o_ctl[2]), 64'h0);
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_ready", 64'(o_ctl[0]), 64'h1);
        chk("post_rst_done1", 64'(o_ctl[2]), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
